// File: rtl/xbar_pkg.sv
// Shared types and helpers for the crossbar target-side arbiter.
package xbar_pkg;

  localparam int unsigned MaxNumIn = 64;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xbar_spill_reg.sv
// One-entry valid/ready register stage: one cycle latency, full throughput,
// and valid_o depends only on the stored state.
module xbar_spill_reg #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o
);

  logic             full_q;
  logic [Width-1:0] data_q;

  // Accept when empty, or when the held entry leaves in this same cycle.
  assign ready_o = !full_q || ready_i;
  assign valid_o = full_q;
  assign data_o  = data_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
    end else if (ready_o) begin
      full_q <= valid_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (ready_o && valid_i) begin
      data_q <= data_i;
    end
  end

endmodule

// File: rtl/xbar_target_arbiter.sv
// Round-robin arbiter letting NumIn initiators share one target, with an
// optional grant lock (valid/ready mode) and an optional output register.
module xbar_target_arbiter
  import xbar_pkg::*;
#(
  parameter int unsigned NumIn     = 4,
  parameter int unsigned DataWidth = 32,
  parameter bit          AxiVldRdy = 1'b1,
  parameter bit          SpillReg  = 1'b0,
  localparam int unsigned IdxW     = idx_width(NumIn)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumIn-1:0]               valid_i,
  output logic [NumIn-1:0]               ready_o,
  input  logic [NumIn-1:0][DataWidth-1:0] data_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [DataWidth-1:0]           data_o,
  output logic [IdxW-1:0]                idx_o
);

  if (NumIn == 0 || NumIn > MaxNumIn) begin : g_bad_num_in
    $fatal(1, "xbar_target_arbiter: NumIn must be within 1..64");
  end

  arb_state_e           state_q;
  logic [IdxW-1:0]      rr_q;
  logic [IdxW-1:0]      lock_idx_q;
  logic [IdxW-1:0]      scan_idx;
  logic [IdxW-1:0]      cand;
  logic                 scan_found;
  logic [IdxW-1:0]      win_idx;
  logic [DataWidth-1:0] win_data;
  logic                 locked;
  logic                 arb_valid;
  logic                 down_ready;
  logic                 xfer;

  // First asserted request at or above the pointer, wrapping at NumIn-1.
  always_comb begin
    scan_idx   = '0;
    scan_found = 1'b0;
    cand       = '0;
    for (int unsigned k = 0; k < NumIn; k++) begin
      cand = IdxW'((32'(rr_q) + k) % NumIn);
      if (!scan_found && valid_i[cand]) begin
        scan_found = 1'b1;
        scan_idx   = cand;
      end
    end
  end

  assign locked    = (state_q == LOCKED);
  assign win_idx   = locked ? lock_idx_q : scan_idx;
  assign win_data  = data_i[win_idx];
  // Masking with rst_ni keeps every handshake silent while reset is held.
  assign arb_valid = rst_ni && (locked ? valid_i[lock_idx_q] : scan_found);
  assign xfer      = arb_valid && down_ready;

  for (genvar gi = 0; gi < NumIn; gi++) begin : g_ready
    assign ready_o[gi] = xfer && (win_idx == IdxW'(gi));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      lock_idx_q <= '0;
    end else begin
      if (xfer) begin
        rr_q <= (win_idx == IdxW'(NumIn - 1)) ? '0 : win_idx + IdxW'(1);
      end
      case (state_q)
        IDLE: begin
          if (AxiVldRdy && arb_valid && !down_ready) begin
            state_q    <= LOCKED;
            lock_idx_q <= win_idx;
          end
        end
        LOCKED: begin
          if (down_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  if (SpillReg) begin : g_spill
    logic                      sp_valid;
    logic [IdxW+DataWidth-1:0] sp_data;

    xbar_spill_reg #(
      .Width(IdxW + DataWidth)
    ) u_spill (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .valid_i(arb_valid),
      .ready_o(down_ready),
      .data_i ({win_idx, win_data}),
      .valid_o(sp_valid),
      .ready_i(ready_i),
      .data_o (sp_data)
    );

    assign valid_o         = sp_valid && rst_ni;
    assign {idx_o, data_o} = sp_data;
  end else begin : g_direct
    assign down_ready = ready_i;
    assign valid_o    = arb_valid;
    assign data_o     = win_data;
    assign idx_o      = win_idx;
  end

endmodule
